matmul_ctrl: RTL and testbench

//  Sequencer and MAC engine for the 4x8 by 8x4 coefficient product P = X * A.

---
 rtl/matmul_ctrl_pkg.sv | 28 ++
 rtl/matmul_ctrl_if.sv | 24 ++
 rtl/matmul_mac.sv | 52 +++++
 rtl/matmul_ctrl.sv | 141 ++++++++++++++
 tb/tb_matmul_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_ctrl_pkg.sv
// rtl/matmul_ctrl_pkg.sv - widths, dimensions and FSM encoding for the 4x8 by 8x4 MAC sequencer
// Build option MATMUL_SIGNED_EN (consumed by matmul_mac) selects two's complement X samples.
package matmul_ctrl_pkg;
    localparam int COEF_W   = 7;
    localparam int X_W      = 8;
    localparam int ACC_W    = 18;
    localparam int A_WORD_W = 2 * COEF_W;
    localparam int X_WORD_W = 2 * X_W;
    localparam int ROWS     = 4;
    localparam int K        = 8;
    localparam int K_WORDS  = K / 2;
    localparam int COLS     = 4;
    localparam int CNT_W    = 2;
    localparam int ADDR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_WRITE     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic logic is_last(input logic [CNT_W-1:0] v, input int n);
        return v == CNT_W'(n - 1);
    endfunction
endpackage

// File: rtl/matmul_ctrl_if.sv
// rtl/matmul_ctrl_if.sv - coefficient/sample memory read port and result write port
// Master side is the sequencer; slave side is the memories and the result consumer.
interface matmul_ctrl_if;
    import matmul_ctrl_pkg::*;

    logic                mem_re;
    logic [ADDR_W-1:0]   a_addr;
    logic [ADDR_W-1:0]   x_addr;
    logic [A_WORD_W-1:0] a_rdata;
    logic [X_WORD_W-1:0] x_rdata;
    logic                res_we;
    logic [ADDR_W-1:0]   res_addr;
    logic [ACC_W-1:0]    res_data;

    modport master (
        output mem_re, a_addr, x_addr, res_we, res_addr, res_data,
        input  a_rdata, x_rdata
    );

    modport slave (
        input  mem_re, a_addr, x_addr, res_we, res_addr, res_data,
        output a_rdata, x_rdata
    );
endinterface

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - dual-lane multiply, add and accumulate for one result element
// MATMUL_SIGNED_EN: X lanes are two's complement and products are sign-extended.
module matmul_mac
    import matmul_ctrl_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [A_WORD_W-1:0] i_a_word,
    input  logic [X_WORD_W-1:0] i_x_word,
    output logic [ACC_W-1:0]    o_acc
);
    localparam int PW = X_W + COEF_W;

    logic [COEF_W-1:0] w_a_hi, w_a_lo;
    logic [X_W-1:0]    w_x_hi, w_x_lo;
    logic [ACC_W-1:0]  w_prod_hi, w_prod_lo, w_sum;
    logic [ACC_W-1:0]  r_acc;

    assign w_a_hi = i_a_word[A_WORD_W-1:COEF_W];
    assign w_a_lo = i_a_word[COEF_W-1:0];
    assign w_x_hi = i_x_word[X_WORD_W-1:X_W];
    assign w_x_lo = i_x_word[X_W-1:0];

`ifdef MATMUL_SIGNED_EN
    // Coefficients stay unsigned, so give them a zero sign bit before the signed multiply.
    logic signed [PW:0] w_sp_hi, w_sp_lo;
    assign w_sp_hi   = (PW+1)'($signed(w_x_hi)) * (PW+1)'($signed({1'b0, w_a_hi}));
    assign w_sp_lo   = (PW+1)'($signed(w_x_lo)) * (PW+1)'($signed({1'b0, w_a_lo}));
    assign w_prod_hi = {{(ACC_W-PW-1){w_sp_hi[PW]}}, w_sp_hi};
    assign w_prod_lo = {{(ACC_W-PW-1){w_sp_lo[PW]}}, w_sp_lo};
`else
    logic [PW-1:0] w_up_hi, w_up_lo;
    assign w_up_hi   = PW'(w_x_hi) * PW'(w_a_hi);
    assign w_up_lo   = PW'(w_x_lo) * PW'(w_a_lo);
    assign w_prod_hi = {{(ACC_W-PW){1'b0}}, w_up_hi};
    assign w_prod_lo = {{(ACC_W-PW){1'b0}}, w_up_lo};
`endif

    assign w_sum = w_prod_hi + w_prod_lo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_clr ? w_sum : r_acc + w_sum;
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - sequencer for P = X * A: walks both memories and writes 16 results row-major
// Signed X samples under MATMUL_SIGNED_EN are handled inside matmul_mac.
module matmul_ctrl
    import matmul_ctrl_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_aload_done,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    matmul_ctrl_if.master mem
);
    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_row, r_col, r_k;
    logic              r_rd_vld, r_rd_first;
    logic [ADDR_W-1:0] r_a_addr_q, r_x_addr_q;
    logic [ACC_W-1:0]  r_res_q, w_acc;
    logic              w_mem_re, w_res_we, w_busy, w_done;
    logic              w_last_k, w_last_col, w_last_elem;

    assign w_last_k    = is_last(r_k, K_WORDS);
    assign w_last_col  = is_last(r_col, COLS);
    assign w_last_elem = is_last(r_row, ROWS) && w_last_col;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_re    = 1'b0;
        w_res_we    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = i_aload_done ? ST_ISSUE : ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                w_busy = 1'b1;
                if (i_aload_done) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_busy   = 1'b1;
                w_mem_re = 1'b1;
                if (w_last_k) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_busy      = 1'b1;
                w_res_we    = 1'b1;
                w_state_nxt = w_last_elem ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                ST_ISSUE: r_k <= w_last_k ? '0 : r_k + CNT_W'(1);
                ST_WRITE: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + CNT_W'(1);
                    end else begin
                        r_col <= r_col + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_row <= '0;
                    r_col <= '0;
                    r_k   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Memories answer one cycle after the strobe; the k=0 beat overwrites the accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_a_addr_q <= '0;
            r_x_addr_q <= '0;
            r_res_q    <= '0;
        end else begin
            r_rd_vld   <= w_mem_re;
            r_rd_first <= w_mem_re && (r_k == '0);
            if (w_mem_re) begin
                r_a_addr_q <= {r_col, r_k};
                r_x_addr_q <= {r_row, r_k};
            end
            if (w_res_we) begin
                r_res_q <= w_acc;
            end
        end
    end

    matmul_mac u_mac (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (r_rd_vld),
        .i_clr    (r_rd_first),
        .i_a_word (mem.a_rdata),
        .i_x_word (mem.x_rdata),
        .o_acc    (w_acc)
    );

    assign mem.mem_re   = w_mem_re;
    assign mem.a_addr   = w_mem_re ? {r_col, r_k} : r_a_addr_q;
    assign mem.x_addr   = w_mem_re ? {r_row, r_k} : r_x_addr_q;
    assign mem.res_we   = w_res_we;
    assign mem.res_addr = {r_row, r_col};
    assign mem.res_data = w_res_we ? w_acc : r_res_q;
    assign o_busy       = w_busy;
    assign o_done       = w_done;
endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - directed self-checking bench for matmul_ctrl
// Build with MATMUL_SIGNED_EN to swap the full-scale unsigned run for the signed one.
module tb_matmul_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic aload_done = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    matmul_ctrl_if u_if ();

    matmul_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_aload_done (aload_done),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .mem          (u_if)
    );

    always #5 clk = ~clk;

    logic [13:0] a_mem [16];
    logic [15:0] x_mem [16];
    logic [31:0] exp_res [16];

    always @(posedge clk) begin
        if (u_if.mem_re) begin
            u_if.a_rdata <= a_mem[u_if.a_addr];
            u_if.x_rdata <= x_mem[u_if.x_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int wr_cnt, done_cnt, re_cnt, first_re_cyc, done_cyc;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_cyc  [32];

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.res_we && wr_cnt < 32) begin
                wr_addr[wr_cnt] = 32'(u_if.res_addr);
                wr_data[wr_cnt] = 32'(u_if.res_data);
                wr_cyc[wr_cnt]  = cyc;
                wr_cnt = wr_cnt + 1;
            end
            if (u_if.mem_re) begin
                if (re_cnt == 0) first_re_cyc = cyc;
                re_cnt = re_cnt + 1;
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt = done_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [13:0] aw, input logic [15:0] xw);
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = aw;
            x_mem[i] = xw;
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; re_cnt = 0; first_re_cyc = -1; done_cyc = -1;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int budget = 0;
        while (done_cnt == 0 && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_results(input string tag, input int t0, input bit timing);
        chk({tag, "_nwr"}, 32'(wr_cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_res[i]);
        end
        if (timing) begin
            chk({tag, "_t_first_wr"}, 32'(wr_cyc[0] - t0), 32'd6);
            chk({tag, "_t_last_wr"}, 32'(wr_cyc[15] - t0), 32'd96);
            chk({tag, "_t_done"}, 32'(done_cyc - t0), 32'd97);
        end
    endtask

    task automatic run_product(input string tag, input bit poke_busy);
        int t0;
        clear_mon();
        pulse_start(t0);
        if (poke_busy) begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(tag);
        check_results(tag, t0, 1'b1);
    endtask

    initial begin
        int s, t0;
        bit found;
        clear_mon();
        fill('0, '0);
        u_if.a_rdata = '0;
        u_if.x_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_re", 32'(u_if.mem_re), 0);
        chk("rst_res_we", 32'(u_if.res_we), 0);
        chk("rst_res_data", 32'(u_if.res_data), 0);
        chk("rst_a_addr", 32'(u_if.a_addr), 0);
        rst_n = 1'b1;
        aload_done = 1'b1;

        fill(14'h0081, 16'h0101);
        for (int i = 0; i < 16; i++) exp_res[i] = 32'd8;
        run_product("ones", 1'b0);

        fill('0, '0);
        for (int k = 0; k < 4; k++) begin
            a_mem[k] = {7'(2*k+1), 7'(2*k+2)};
            x_mem[k] = 16'h0101;
        end
        for (int i = 0; i < 16; i++) exp_res[i] = 32'd0;
        exp_res[0] = 32'd36;
        run_product("col_ramp", 1'b0);

        fill(14'h0081, 16'h0101);
        for (int k = 0; k < 4; k++) a_mem[k] = '0;
        for (int i = 0; i < 16; i++) exp_res[i] = (i % 4 == 0) ? 32'd0 : 32'd8;
        run_product("col_zero", 1'b0);

`ifdef MATMUL_SIGNED_EN
        fill(14'h3FFF, 16'h8080);
        for (int i = 0; i < 16; i++) exp_res[i] = 32'h20400;
        run_product("signed_min", 1'b1);
`else
        fill(14'h3FFF, 16'hFFFF);
        for (int i = 0; i < 16; i++) exp_res[i] = 32'h3F408;
        run_product("full_scale", 1'b1);
`endif

        fill(14'h0081, 16'h0101);
        for (int i = 0; i < 16; i++) exp_res[i] = 32'd8;
        aload_done = 1'b0;
        clear_mon();
        pulse_start(t0);
        repeat (9) @(posedge clk);
        #1;
        chk("wl_no_re", 32'(re_cnt), 0);
        chk("wl_busy", 32'(busy), 1);
        aload_done = 1'b1;
        s = cyc;
        repeat (4) @(posedge clk);
        #1 aload_done = 1'b0;
        wait_done("wl");
        chk("wl_first_re", 32'(first_re_cyc - s), 32'd1);
        check_results("wl", t0, 1'b0);
        aload_done = 1'b1;

        clear_mon();
        pulse_start(t0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (u_if.res_we && u_if.res_addr == 4'd5) found = 1'b1;
        end
        chk("mr_found_wr5", 32'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_res_we", 32'(u_if.res_we), 0);
        chk("mr_mem_re", 32'(u_if.mem_re), 0);
        chk("mr_res_data", 32'(u_if.res_data), 0);
        chk("mr_wr_before", 32'(wr_cnt), 32'd6);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mr_no_more_wr", 32'(wr_cnt), 32'd6);
        run_product("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
